gc_netlist_sequencer: RTL and testbench

Controller that sequences one GarbledCircuit run end to end.
- On a request it fetches the netlist image from a synchronous netlist memory.
- It issues the one-cycle start pulse, then streams the 4 header words and all DFF/gate words onto the netlist input, one word per cycle.
- It then monitors the circuit's clock-cycle id until CC cycles have been garbled, and reports completion.
- Sits between the host/control logic and the GarbledCircuit core; replaces bench-driven netlist loading.

---
 rtl/gc_netlist_sequencer.sv | 134 +++++++++++++
 tb/tb_gc_netlist_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/gc_netlist_sequencer.sv
// gc_netlist_sequencer: fetches a netlist image, streams it into GarbledCircuit and waits for CC cycles to finish.
// Optional GC_SEQ_CYCLE_COUNT_EN adds the run_cycles counter output.
module gc_netlist_sequencer #(
  parameter int S      = 8,
  parameter int CC     = 4,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  output logic              gc_start,
  output logic [31:0]       gc_netlist_in,
  input  logic [S-1:0]      gc_cid
`ifdef GC_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]       run_cycles
`endif
);
  localparam int TW = (ADDR_W + 1 > S + 2) ? ADDR_W + 1 : S + 2;
  localparam logic [TW-1:0] MEMW = TW'(2 ** ADDR_W);
  localparam logic [TW-1:0] W2 = TW'(2);
  localparam logic [TW-1:0] W3 = TW'(3);
  localparam logic [TW-1:0] W4 = TW'(4);
  typedef enum logic [2:0] {IDLE, PREFETCH, START, STREAM, RUN} state_t;
  state_t              state_q;
  logic                mem_rd_q, start_q, done_q, err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         nl_q;
  logic [TW-1:0]       widx_q, t_q, t_d, lim;
  logic [S-1:0]        dff_q;
  logic                more_rd;
`ifdef GC_SEQ_CYCLE_COUNT_EN
  logic [31:0]         cyc_q;
  assign run_cycles = cyc_q;
`endif
  // widx_q is the index of the word being captured; the total is known once word3 is on mem_data
  always_comb begin
    t_d     = W4 + TW'(dff_q) + TW'(mem_data[S-1:0]);
    lim     = (widx_q == W3) ? t_d - TW'(1) : (widx_q > W3) ? t_q - TW'(1) : MEMW - TW'(1);
    more_rd = mem_rd_q && (TW'(addr_q) < lim);
  end
  assign busy          = state_q != IDLE;
  assign done          = done_q;
  assign err           = err_q;
  assign mem_rd        = mem_rd_q;
  assign mem_addr      = addr_q;
  assign gc_start      = start_q;
  assign gc_netlist_in = nl_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mem_rd_q <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      nl_q     <= '0;
      widx_q   <= '0;
      t_q      <= '0;
      dff_q    <= '0;
`ifdef GC_SEQ_CYCLE_COUNT_EN
      cyc_q    <= '0;
`endif
    end else if (abort && state_q != IDLE) begin
      state_q  <= IDLE;
      mem_rd_q <= 1'b0;
      start_q  <= 1'b0;
      nl_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (go && !abort) begin
            err_q    <= 1'b0;
            mem_rd_q <= 1'b1;
            addr_q   <= '0;
            state_q  <= PREFETCH;
`ifdef GC_SEQ_CYCLE_COUNT_EN
            cyc_q    <= '0;
`endif
          end
        end
        PREFETCH: begin
          addr_q  <= ADDR_W'(1);
          start_q <= 1'b1;
          state_q <= START;
        end
        START: begin
          start_q <= 1'b0;
          nl_q    <= mem_data;
          addr_q  <= ADDR_W'(2);
          widx_q  <= TW'(1);
          state_q <= STREAM;
        end
        STREAM: begin
          if (widx_q > W3 && widx_q == t_q) begin
            nl_q     <= '0;
            mem_rd_q <= 1'b0;
            state_q  <= RUN;
          end else if (widx_q == W3 && t_d > MEMW) begin
            err_q    <= 1'b1;
            nl_q     <= '0;
            mem_rd_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            nl_q     <= mem_data;
            widx_q   <= widx_q + TW'(1);
            mem_rd_q <= more_rd;
            addr_q   <= more_rd ? addr_q + ADDR_W'(1) : addr_q;
            dff_q    <= (widx_q == W2) ? mem_data[2*S-1:S] : dff_q;
            t_q      <= (widx_q == W3) ? t_d : t_q;
          end
        end
        RUN: begin
`ifdef GC_SEQ_CYCLE_COUNT_EN
          cyc_q <= cyc_q + 32'd1;
`endif
          if (gc_cid == S'(CC)) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gc_netlist_sequencer.sv
// tb_gc_netlist_sequencer: table-driven and directed checks of the netlist sequencer with a synchronous memory model.
module tb_gc_netlist_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, err, mem_rd, gc_start;
  logic [3:0]  mem_addr;
  logic [31:0] mem_data = 32'h0;
  logic [31:0] gc_netlist_in;
  logic [7:0]  gc_cid = 8'h0;
`ifdef GC_SEQ_CYCLE_COUNT_EN
  logic [31:0] run_cycles;
`endif
  logic [31:0] mem [16];
  logic [31:0] w [10];
  int          n_chk = 0;
  int          n_fail = 0;
  int          starts = 0;
  int          s0;
  typedef struct {
    logic        go;
    logic [7:0]  cid;
    logic        busy;
    logic        start;
    logic        done;
    logic [31:0] nl;
  } vec_t;
  vec_t tbl [19];

  gc_netlist_sequencer #(.S(8), .CC(4), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .busy(busy), .done(done), .err(err),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .gc_start(gc_start),
    .gc_netlist_in(gc_netlist_in), .gc_cid(gc_cid)
`ifdef GC_SEQ_CYCLE_COUNT_EN
    , .run_cycles(run_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];
  always @(posedge clk) if (gc_start) starts <= starts + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_main();
    w[0] = 32'h0203; w[1] = 32'h0104; w[2] = 32'h0205; w[3] = 32'h0104;
    for (int k = 4; k < 10; k++) w[k] = 32'hC000_0000 + 32'(k);
    for (int k = 0; k < 16; k++) mem[k] = (k < 10) ? w[k] : 32'hDEAD_0000 + 32'(k);
  endtask

  initial begin
    load_main();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_outs", {25'b0, done, err, mem_rd, gc_start, mem_addr == 4'd0, 1'b0, 1'b0}, 32'h4);
    chk("rst_nl", gc_netlist_in, 0);
    rst = 1'b1;
    step();
    go = 1'b1; abort = 1'b1;
    step();
    chk("go_abort_idle", 32'(busy), 0);
    go = 1'b0; abort = 1'b0;
    step();

    for (int i = 0; i < 19; i++) begin
      tbl[i].go    = (i < 2 || i == 3);
      tbl[i].cid   = (i < 2) ? 8'd0 : (i >= 13 && i <= 16) ? 8'(i - 13) : 8'd4;
      tbl[i].busy  = (i < 17);
      tbl[i].start = (i == 1);
      tbl[i].done  = (i == 17);
      tbl[i].nl    = (i >= 2 && i <= 11) ? w[i-2] : 32'h0;
    end
    s0 = starts;
    for (int i = 0; i < 19; i++) begin
      go = tbl[i].go;
      gc_cid = tbl[i].cid;
      step();
      chk($sformatf("main_busy[%0d]", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("main_start[%0d]", i), 32'(gc_start), 32'(tbl[i].start));
      chk($sformatf("main_nl[%0d]", i), gc_netlist_in, tbl[i].nl);
      chk($sformatf("main_done[%0d]", i), 32'(done), 32'(tbl[i].done));
    end
    go = 1'b0;
    chk("main_one_start", 32'(starts - s0), 1);

    gc_cid = 8'd0;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h0; mem[3] = 32'h0;
    for (int k = 4; k < 16; k++) mem[k] = 32'hBAD;
    go = 1'b1; step(); go = 1'b0;
    step(); chk("z_start", 32'(gc_start), 1);
    step(); chk("z_w0", gc_netlist_in, 32'h11);
    step(); chk("z_w1", gc_netlist_in, 32'h22);
    step(); chk("z_w2", gc_netlist_in, 0);
    step(); chk("z_w3", gc_netlist_in, 0);
    step(); chk("z_run_nl", gc_netlist_in, 0); chk("z_run_busy", 32'(busy), 1);
    gc_cid = 8'd4;
    step(); chk("z_done", 32'(done), 1); chk("z_nl_idle", gc_netlist_in, 0);
    gc_cid = 8'd0;
    step();

    mem[0] = 32'h31; mem[1] = 32'h32; mem[2] = 32'h0A00; mem[3] = 32'h0008;
    for (int k = 4; k < 16; k++) mem[k] = 32'h77;
    go = 1'b1; step(); go = 1'b0;
    repeat (4) step();
    chk("e_w2", gc_netlist_in, 32'h0A00);
    step();
    chk("e_busy", 32'(busy), 0); chk("e_err", 32'(err), 1); chk("e_nl", gc_netlist_in, 0);
    gc_cid = 8'd4;
    for (int k = 0; k < 4; k++) begin
      step(); chk($sformatf("e_nodone[%0d]", k), 32'(done), 0);
    end
    chk("e_err_sticky", 32'(err), 1);

    gc_cid = 8'd0;
    load_main();
    go = 1'b1; step(); go = 1'b0;
    chk("a_err_clr", 32'(err), 0);
    chk("a_rd", {mem_rd, 27'b0, mem_addr}, 32'h8000_0000);
    repeat (4) step();
    chk("a_pre_nl", gc_netlist_in, w[2]);
    abort = 1'b1; step(); abort = 1'b0;
    chk("a_busy", 32'(busy), 0); chk("a_nl", gc_netlist_in, 0); chk("a_rd0", 32'(mem_rd), 0);
    gc_cid = 8'd4;
    for (int k = 0; k < 3; k++) begin
      step(); chk($sformatf("a_nodone[%0d]", k), 32'(done), 0);
    end
    gc_cid = 8'd0;
    s0 = starts;
    go = 1'b1; step();
    chk("r_addr0", {mem_rd, 27'b0, mem_addr}, 32'h8000_0000);
    step(); chk("r_start", 32'(gc_start), 1);
    for (int k = 0; k < 11; k++) step();
    go = 1'b0;
    chk("r_one_start", 32'(starts - s0), 1);
    chk("r_run_busy", 32'(busy), 1);
    step();
    rst = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_outs", {26'b0, done, err, mem_rd, gc_start, mem_addr == 4'd0, 1'b0}, 32'h2);
    chk("ar_nl", gc_netlist_in, 0);
    step();
    rst = 1'b1;
    step();

`ifdef GC_SEQ_CYCLE_COUNT_EN
    chk("c_rst", run_cycles, 0);
    go = 1'b1; step(); go = 1'b0;
    for (int k = 0; k < 12; k++) step();
    for (int k = 0; k < 6; k++) step();
    chk("c_busy", 32'(busy), 1);
    gc_cid = 8'd4;
    step();
    chk("c_done", 32'(done), 1);
    chk("c_cnt", run_cycles, 7);
    step(); step();
    chk("c_hold", run_cycles, 7);
    gc_cid = 8'd0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
